// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 32-bit ALU: FIFO-buffered commands issued one at a time, results returned on a valid/ready channel.
// Optional: define ALU_CMD_SEQ_ERR_FLUSH_EN to flush queued commands and block new ones after an ALU error.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  NOOP_OP = 4'b1110,
  parameter logic [3:0]  CLR_OP  = 4'b1100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_p,
  input  logic [31:0] cmd_q,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic [3:0]  rsp_op,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_p,
  output logic [31:0] alu_q,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        busy,
  output logic        err_sticky,
  input  logic        err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } seqState_e;

  seqState_e state;
  seqState_e nextState;

  logic [3:0]  memOp [DEPTH];
  logic [31:0] memP  [DEPTH];
  logic [31:0] memQ  [DEPTH];

  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] rdPtrNext;
  logic [AW:0]   count;
  logic [AW:0]   countNext;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic flush;

  logic [3:0]  aluOpNext;
  logic [31:0] aluPNext;
  logic [31:0] aluQNext;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

`ifdef ALU_CMD_SEQ_ERR_FLUSH_EN
  assign cmd_ready = !full && !err_sticky;
  assign flush     = (state == ST_ISSUE) && (alu_error != 2'b00);
`else
  assign cmd_ready = !full;
  assign flush     = 1'b0;
`endif

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == ST_ISSUE);
  assign busy = (state != ST_IDLE) || !empty;

  // A push landing on the flush edge is a completed handshake, so it survives.
  always_comb begin
    countNext = count;
    rdPtrNext = rdPtr;
    if (flush) begin
      countNext = push ? (AW + 1)'(1) : '0;
      rdPtrNext = wrPtr;
    end else begin
      if (pop) begin
        rdPtrNext = rdPtr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   countNext = count + 1'b1;
        2'b01:   countNext = count - 1'b1;
        default: countNext = count;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_INIT:  nextState = ST_IDLE;
      ST_IDLE:  if (!empty) nextState = ST_ISSUE;
      ST_ISSUE: nextState = ST_RESP;
      ST_RESP:  if (rsp_ready) nextState = empty ? ST_IDLE : ST_ISSUE;
      default:  nextState = ST_INIT;
    endcase
  end

  // ALU drive is registered from the next state, so it is stable through ISSUE.
  always_comb begin
    aluOpNext = NOOP_OP;
    aluPNext  = '0;
    aluQNext  = '0;
    if (nextState == ST_ISSUE) begin
      aluOpNext = memOp[rdPtr];
      aluPNext  = memP[rdPtr];
      aluQNext  = memQ[rdPtr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memOp[wrPtr] <= cmd_op;
      memP[wrPtr]  <= cmd_p;
      memQ[wrPtr]  <= cmd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      state <= nextState;
      rdPtr <= rdPtrNext;
      count <= countNext;
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= CLR_OP;
      alu_p  <= '0;
      alu_q  <= '0;
    end else begin
      alu_op <= aluOpNext;
      alu_p  <= aluPNext;
      alu_q  <= aluQNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= '0;
      rsp_op    <= '0;
    end else if (state == ST_ISSUE) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_err   <= alu_error;
      rsp_op    <= alu_op;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if ((state == ST_ISSUE) && (alu_error != 2'b00)) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU (add/sub/mult/div, clear, feedback).
// Expectations adapt when ALU_CMD_SEQ_ERR_FLUSH_EN is defined.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_p;
  logic [31:0] cmd_q;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [3:0]  rsp_op;
  logic [3:0]  alu_op;
  logic [31:0] alu_p;
  logic [31:0] alu_q;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        busy;
  logic        err_sticky;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
    logic [3:0]  op;
  } rsp_t;

  rsp_t expQ[$];
  rsp_t monExp;

  alu_cmd_sequencer #(
    .DEPTH  (DEPTH),
    .NOOP_OP(4'b1110),
    .CLR_OP (4'b1100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_p     (cmd_p),
    .cmd_q     (cmd_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_op    (rsp_op),
    .alu_op    (alu_op),
    .alu_p     (alu_p),
    .alu_q     (alu_q),
    .alu_result(alu_result),
    .alu_error (alu_error),
    .busy      (busy),
    .err_sticky(err_sticky),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: Q=0 selects the state register, which loads the mux output every edge.
  logic [31:0] aluState = 32'hDEAD_BEEF;
  logic [31:0] qEff;
  logic [32:0] sum33;

  assign qEff = (alu_q == 32'd0) ? aluState : alu_q;

  always_comb begin
    alu_result = aluState;
    alu_error  = 2'b00;
    sum33      = {1'b0, alu_p} + {1'b0, qEff};
    case (alu_op)
      4'b0000: begin
        alu_result = sum33[31:0];
        if (sum33[32]) alu_error = 2'b10;
      end
      4'b0001: alu_result = alu_p - qEff;
      4'b0010: alu_result = alu_p * qEff;
      4'b0011: begin
        if (alu_p == 32'd0) begin
          alu_result = 32'd0;
          alu_error  = 2'b01;
        end else begin
          alu_result = qEff / alu_p;
        end
      end
      4'b1100: alu_result = 32'd0;
      default: alu_result = aluState;
    endcase
  end

  always @(posedge clk) aluState <= alu_result;

  // Monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got data=%0d err=%b op=%b, required no response",
                 rsp_data, rsp_err, rsp_op);
      end else begin
        monExp = expQ.pop_front();
        if (rsp_data !== monExp.data || rsp_err !== monExp.err || rsp_op !== monExp.op) begin
          errors++;
          $display("FAIL rsp: got data=%0d err=%b op=%b, required data=%0d err=%b op=%b",
                   rsp_data, rsp_err, rsp_op, monExp.data, monExp.err, monExp.op);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic pushCmd(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                         input bit expectRsp, input logic [31:0] expData, input logic [1:0] expErr);
    int budget;
    bit ok;
    budget    = 0;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_p     = p;
    cmd_q     = q;
    if (expectRsp) expQ.push_back('{data: expData, err: expErr, op: op});
    while (!ok && budget < 50) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      budget++;
    end
    #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got cmd_ready=0 for %0d cycles, required 1", budget);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((expQ.size() != 0 || busy) && b < 200) begin
      @(posedge clk);
      b++;
    end
    #1;
    checks++;
    if (b >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", expQ.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_p     = '0;
    cmd_q     = '0;
    rsp_ready = 1'b1;
    err_clr   = 1'b0;

    // Reset values
    waitCycles(3);
    check("rst_alu_op", 32'(alu_op), 32'hC);
    check("rst_alu_p", alu_p, 32'd0);
    check("rst_alu_q", alu_q, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_op", 32'(rsp_op), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // INIT holds CLR_OP for one cycle, then feedback
    rst_n = 1'b1;
    #2;
    check("init_op", 32'(alu_op), 32'hC);
    @(posedge clk); #1;
    check("idle_op", 32'(alu_op), 32'hE);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    waitCycles(3);
    check("idle_op_steady", 32'(alu_op), 32'hE);

    // Single add with issue latency
    pushCmd(4'b0000, 32'd5, 32'd7, 1'b1, 32'd12, 2'b00);
    check("add_lat1_op", 32'(alu_op), 32'hE);
    @(posedge clk); #1;
    check("add_issue_op", 32'(alu_op), 32'h0);
    check("add_issue_p", alu_p, 32'd5);
    check("add_issue_q", alu_q, 32'd7);
    @(posedge clk); #1;
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Chaining through the ALU state register
    pushCmd(4'b0010, 32'd3, 32'd4, 1'b1, 32'd12, 2'b00);
    pushCmd(4'b0000, 32'd10, 32'd0, 1'b1, 32'd22, 2'b00);
    drain();

    // Backpressure: DEPTH+1 commands, first sits in RESP
    rsp_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      pushCmd(4'b0000, 32'(i), 32'(16 * i), 1'b1, 32'(17 * i), 2'b00);
    end
    check("bp_full_ready", 32'(cmd_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rsp_data", rsp_data, 32'd17);
    waitCycles(4);
    check("bp_hold_valid", 32'(rsp_valid), 32'd1);
    check("bp_hold_data", rsp_data, 32'd17);
    check("bp_hold_op", 32'(rsp_op), 32'h0);
    check("bp_hold_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    drain();

    // Error handling
    pushCmd(4'b0011, 32'd0, 32'd8, 1'b1, 32'd0, 2'b01);
`ifdef ALU_CMD_SEQ_ERR_FLUSH_EN
    pushCmd(4'b0000, 32'd1, 32'd1, 1'b0, 32'd0, 2'b00);
`else
    pushCmd(4'b0000, 32'd1, 32'd1, 1'b1, 32'd2, 2'b00);
`endif
    drain();
    waitCycles(3);
    check("err_sticky_set", 32'(err_sticky), 32'd1);
`ifdef ALU_CMD_SEQ_ERR_FLUSH_EN
    check("err_cmd_ready", 32'(cmd_ready), 32'd0);
`else
    check("err_cmd_ready", 32'(cmd_ready), 32'd1);
`endif
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_sticky_clr", 32'(err_sticky), 32'd0);
    check("err_clr_ready", 32'(cmd_ready), 32'd1);

    // Reset while in RESP with two commands queued
    rsp_ready = 1'b0;
    pushCmd(4'b0000, 32'd7, 32'd7, 1'b0, 32'd0, 2'b00);
    pushCmd(4'b0000, 32'd8, 32'd8, 1'b0, 32'd0, 2'b00);
    pushCmd(4'b0000, 32'd9, 32'd9, 1'b0, 32'd0, 2'b00);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_op", 32'(alu_op), 32'hC);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    check("mid_init_op", 32'(alu_op), 32'hC);
    @(posedge clk); #1;
    check("mid_idle_op", 32'(alu_op), 32'hE);
    check("mid_idle_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b1;
    waitCycles(6);
    check("mid_no_stale", 32'(rsp_valid), 32'd0);
    pushCmd(4'b0000, 32'd2, 32'd3, 1'b1, 32'd5, 2'b00);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front-end for the 32-bit ALU. Buffers opcode/operand commands in a small FIFO and issues them to the ALU one at a time.
- Captures the ALU result and error code, and returns them on a valid/ready response channel.
- Clears the ALU state register after reset. Holds the ALU state with the feedback opcode whenever no command is in flight.

Parameters:
- DEPTH, 4, command FIFO depth; must be a power of 2 and at least 2.
- NOOP_OP, 4'b1110, opcode driven while idle (feedback, which holds the ALU state register).
- CLR_OP, 4'b1100, opcode driven in INIT (reset, which loads 0 into the ALU state register).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  4  ALU opcode (0000 add … 1111 exponent).
- cmd_p  in  32  operand P.
- cmd_q  in  32  operand Q; 0 selects the feedback value inside the ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  32  ALU result.
- rsp_err  out  2  ALU error code: 00 none, 01 divide by zero, 10 overflow.
- rsp_op  out  4  opcode of the returned result.
- alu_op  out  4  to ALU opCode.
- alu_p  out  32  to ALU inputP.
- alu_q  out  32  to ALU inputQ.
- alu_result  in  32  from ALU outALU (combinational mux output).
- alu_error  in  2  from ALU errorCode.
- busy  out  1  high in INIT or ISSUE or RESP, or while the FIFO is non-empty.
- err_sticky  out  1  set by any nonzero captured error.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO pointers and count = 0; state = INIT.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, rsp_op = 0, err_sticky = 0.
  - alu_op = CLR_OP, alu_p = 0, alu_q = 0.
- FIFO:
  - cmd_ready = !full (subject to the optional feature).
  - Push and pop in the same cycle are legal at any non-full count; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Outputs to the ALU are registered:
  - INIT: alu_op = CLR_OP, operands 0.
  - ISSUE: alu_op/alu_p/alu_q = FIFO head.
  - All other states: NOOP_OP with operands 0.
- INIT: exactly one cycle after rst_n rises, so the ALU state register captures 0. Then → IDLE.
- IDLE: FIFO non-empty → ISSUE next cycle. A command pushed in cycle n is therefore driven on alu_* in cycle n+2 (push → IDLE sees non-empty → ISSUE).
- ISSUE (1 cycle):
  - ALU inputs are stable for the whole cycle.
  - At the closing edge: rsp_data ← alu_result, rsp_err ← alu_error, rsp_op ← head opcode; FIFO pop; rsp_valid ← 1; → RESP.
  - The ALU state register also loads the result at this edge, so later Q=0 commands chain on it.
- RESP: hold all rsp_* until rsp_ready. On handshake, rsp_valid ← 0 and:
  - FIFO non-empty → ISSUE;
  - FIFO empty → IDLE.
- Throughput: at best one command per 2 cycles. The issue order is strictly FIFO.
- err_sticky: set at the end of ISSUE when alu_error != 00. err_clr clears it, but set wins on the same cycle.
- An unknown opcode needs no special handling; all 16 opcodes pass through.
- If rst_n is asserted mid-operation, the in-flight command, the queued commands and any pending response are discarded with no response. The sequence restarts from INIT.

Optional Feature:
- Macro: ALU_CMD_SEQ_ERR_FLUSH_EN.
- Defined:
  - At the ISSUE edge that captures a nonzero error, every remaining FIFO entry is discarded (count ← 0, rd_ptr ← wr_ptr).
  - The erroring response is still returned.
  - cmd_ready = 0 while err_sticky = 1; a push attempted then is ignored.
- Undefined: errors are only recorded (rsp_err, err_sticky); queued commands continue; cmd_ready = !full.

Test Plan:
- Reset release, no commands → alu_op = 1100 for exactly one cycle, then 1110 steady; busy = 0 after INIT; rsp_valid = 0.
- Push add P=5, Q=7, rsp_ready = 1 → alu_op = 0000 two cycles after the push; rsp_valid the following cycle with rsp_data = 12, rsp_err = 00, rsp_op = 0000.
- Chaining: push mult P=3, Q=4, then add P=10, Q=0 → responses in order, 12 then 22.
- Backpressure: rsp_ready = 0, push DEPTH+1 commands.
  - Required: rsp stable.
  - Required: cmd_ready drops once the FIFO is full (after the first command has been popped into RESP and DEPTH more have been queued).
  - Release rsp_ready → all DEPTH+1 responses are returned in order; none lost or duplicated.
- Error:
  - Push div P=0, Q=8, then add P=1, Q=1 → first response rsp_err = 01 and err_sticky = 1.
  - Without the macro: the add still returns 2.
  - With ALU_CMD_SEQ_ERR_FLUSH_EN: no second response and cmd_ready = 0 until err_clr.
  - err_clr → err_sticky = 0.
- Assert rst_n low while in RESP with 2 commands queued → immediate rsp_valid = 0, FIFO empty, INIT replayed, no stale responses afterwards.
